// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter.
// Holds the arbiter state encoding, counter width and a small one-hot decode helper.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } arb_state_e;

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // One-hot to index for up to 8 requesters; returns 0 for an all-zero vector.
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (oh[k]) begin
            idx = 3'(k);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: the first set request scanning upward
// from last_ptr_i+1 (wrapping at NUM_REQ) wins.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((32'(last_ptr_i) + i) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among NUM_REQ requesters, keeping packets contiguous.
// Define FIFO_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt_o).
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ-1:0]       req_last_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic                     fifo_full_i,
   output logic                     fifo_push_o,
   output logic [WIDTH-1:0]         fifo_push_data_o,
   output logic [IDX_W-1:0]         grant_id_o
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0] grant_cnt_o
`endif
);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic               pick_valid;
   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               accept;
   logic               win_last;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i      (req_valid_i),
      .last_ptr_i (last_ptr_q),
      .grant_o    (pick_grant),
      .valid_o    (pick_valid)
   );

   // Winner selection; a full FIFO or an asserted reset masks every grant.
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      win_oh            = '0;
      win_idx           = owner_q;
      if (state_q == StBurst) begin
         win_oh = owner_oh & req_valid_i;
      end else if (pick_valid) begin
         win_oh  = pick_grant;
         win_idx = IDX_W'(oh2idx(8'(pick_grant)));
      end
      if (fifo_full_i || !reset_n_i) begin
         win_oh = '0;
      end
   end

   assign accept           = |win_oh;
   assign win_last         = req_last_i[win_idx];
   assign req_ready_o      = win_oh;
   assign fifo_push_o      = accept;
   assign fifo_push_data_o = req_data_i[32'(win_idx) * WIDTH +: WIDTH];
   assign grant_id_o       = (state_q == StBurst) ? owner_q : last_ptr_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_ptr_d = last_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               last_ptr_d = win_idx;
               if (!win_last) begin
                  state_d = StBurst;
                  owner_d = win_idx;
               end
            end
         end
         StBurst: begin
            if (accept && win_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         last_ptr_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_ptr_q <= last_ptr_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k] && (cnt_q[k] != CNT_MAX)) begin
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   assign grant_cnt_o = cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: data width; SHALL equal the shared FIFO WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-006 req_last_i  input  NUM_REQ  per-requester final beat of a packet.
REQ-007 req_data_i  input  NUM_REQ*WIDTH  requester k data in slice [k*WIDTH +: WIDTH].
REQ-008 req_ready_o  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-009 fifo_full_i  input  1  full flag from the shared FIFO.
REQ-010 fifo_push_o  output  1  push strobe to the FIFO.
REQ-011 fifo_push_data_o  output  WIDTH  push data to the FIFO.
REQ-012 grant_id_o  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Function
REQ-013 The block SHALL share one FIFO push port among NUM_REQ requesters, with packets kept contiguous in the FIFO.
REQ-014 A beat is accepted when req_valid_i[k] and req_ready_o[k] are both high on a rising edge; requesters SHALL hold valid, data and last stable until accepted.
REQ-015 At most one req_ready_o bit SHALL be high per cycle; req_ready_o SHALL be all-zero while fifo_full_i is high.
REQ-016 fifo_push_o SHALL equal the OR of (req_valid_i & req_ready_o); fifo_push_data_o SHALL be the winner's data; zero-cycle latency, combinational path.
REQ-017 fifo_push_o SHALL never assert while fifo_full_i is high; the FIFO has no overflow protection.
REQ-018 State machine IDLE/BURST; state register plus owner index plus round-robin pointer last_ptr.
REQ-019 In IDLE, the winner SHALL be the first valid requester scanning from last_ptr+1 modulo NUM_REQ.
REQ-020 In IDLE with a winner accepted and last=1: stay IDLE; last_ptr <= winner.
REQ-021 In IDLE with a winner accepted and last=0: go to BURST; owner <= winner; last_ptr <= winner.
REQ-022 In IDLE with fifo_full_i high: no acceptance and no state change; re-arbitrate next cycle.
REQ-023 In BURST, only the owner SHALL be eligible; other requesters' valids are ignored.
REQ-024 In BURST, an accepted owner beat with last=1 SHALL return the machine to IDLE.
REQ-025 In BURST, owner valid low or FIFO full SHALL stall in BURST, with no timeout.
REQ-026 grant_id_o SHALL show the owner in BURST and last_ptr in IDLE.

Reset
REQ-027 Assertion of reset_n_i SHALL immediately force:
- state to IDLE;
- owner to 0;
- last_ptr to NUM_REQ-1, so requester 0 has first priority;
- grant_id_o to NUM_REQ-1;
- all statistics counters to 0.
REQ-028 While reset is asserted, req_ready_o SHALL be 0 and fifo_push_o SHALL be 0.
REQ-029 Reset during BURST SHALL abandon the burst with no further pushes; the partial packet remains in the FIFO.

Configuration
REQ-030 Macro FIFO_ARB_STATS_EN adds output grant_cnt_o, NUM_REQ*16 bits.
REQ-031 grant_cnt_o SHALL hold one 16-bit saturating count of accepted beats per requester; counts hold at 16'hFFFF.
REQ-032 Without FIFO_ARB_STATS_EN, the grant_cnt_o port and the counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the IDLE/BURST state typedef and the constant CNT_W=16.
REQ-034 Sub-module rr_pick SHALL be a combinational rotating-priority encoder with inputs req vector and last_ptr, and outputs a one-hot grant and a valid flag.

Verification
REQ-035 After reset, requesters 0 and 2 each present a single-beat packet with last=1 every cycle, FIFO not full -> grants alternate 0,2,0,2; one push per cycle.
REQ-036 Requester 1 sends a 3-beat packet while requester 3 stays valid -> three consecutive pushes from 1, then requester 3; no interleave.
REQ-037 fifo_full_i held high for 4 cycles mid-burst with requester 1 owning -> ready=0 and push=0 for those cycles; the burst resumes on the same owner after full clears.
REQ-038 reset_n_i pulsed low in BURST on owner 2 -> next cycle state is IDLE; simultaneous valid on 0 and 2 grants requester 0.
REQ-039 With FIFO_ARB_STATS_EN, 70000 single-beat packets from requester 0 -> grant_cnt_o[15:0] = 16'hFFFF; other counters 0.
REQ-040 All four requesters valid with last=1 continuously for 8 cycles -> each is granted exactly twice, in order 0,1,2,3,0,1,2,3.
